// File: rtl/count_monitor_pkg.sv
// Shared constants for count_monitor: default count width and match-FSM state encodings.
package count_monitor_pkg;
  localparam int WIDTH_DEF = 4;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ARMED = 2'd1;
  localparam logic [1:0] HIT   = 2'd2;
endpackage

// File: rtl/count_edge_detect.sv
// Tracks the previous count sample and flags wraps (all-ones -> zero) and, when
// COUNT_MONITOR_STEP_CHECK_EN is defined, any step other than +1 (holds included).
module count_edge_detect
  import count_monitor_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clock,
  input  logic             clear,
  input  logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             step_bad
);

  logic [WIDTH-1:0] prev;
  logic             prev_vld;

  // prev_vld keeps a clear-forced zero from looking like a wrap
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      prev     <= '0;
      prev_vld <= 1'b0;
    end else begin
      prev     <= count;
      prev_vld <= 1'b1;
    end
  end

  assign wrap = prev_vld && (prev == '1) && (count == '0);

`ifdef COUNT_MONITOR_STEP_CHECK_EN
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  assign step_bad = prev_vld && (count != (prev + ONE));
`else
  assign step_bad = 1'b0;
`endif

endmodule

// File: rtl/count_monitor.sv
// Counter monitor: wrap pulses/count/overflow, one-shot target match FSM and an
// optional sticky step-error flag enabled by COUNT_MONITOR_STEP_CHECK_EN.
module count_monitor
  import count_monitor_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clock,
  input  logic             clear,
  input  logic [WIDTH-1:0] count,
  input  logic [WIDTH-1:0] target,
  input  logic             arm,
  output logic             wrap_pulse,
  output logic [WIDTH-1:0] wrap_cnt,
  output logic             wrap_ovf,
  output logic             match_pulse,
  output logic             busy,
  output logic             step_err
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic             wrap;
  logic             step_bad;
  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [WIDTH-1:0] tgt_q;

  count_edge_detect #(.WIDTH(WIDTH)) u_edge (
    .clock    (clock),
    .clear    (clear),
    .count    (count),
    .wrap     (wrap),
    .step_bad (step_bad)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (arm) state_nxt = ARMED;
      ARMED:   if (count == tgt_q) state_nxt = HIT;
      HIT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // busy/match_pulse are registered from the next state so they never glitch
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state       <= IDLE;
      tgt_q       <= '0;
      busy        <= 1'b0;
      match_pulse <= 1'b0;
      wrap_pulse  <= 1'b0;
      wrap_cnt    <= '0;
      wrap_ovf    <= 1'b0;
    end else begin
      state       <= state_nxt;
      busy        <= (state_nxt == ARMED);
      match_pulse <= (state_nxt == HIT);
      if (state == IDLE && arm) tgt_q <= target;
      wrap_pulse  <= wrap;
      if (wrap) begin
        wrap_cnt <= wrap_cnt + ONE;
        if (wrap_cnt == '1) wrap_ovf <= 1'b1;
      end
    end
  end

`ifdef COUNT_MONITOR_STEP_CHECK_EN
  always_ff @(posedge clock or posedge clear) begin
    if (clear) step_err <= 1'b0;
    else if (step_bad) step_err <= 1'b1;
  end
`else
  assign step_err = step_bad;
`endif

endmodule

// File: tb/tb_count_monitor.sv
// Randomized and directed bench for count_monitor against a sample-history reference model.
module tb_count_monitor;
  import count_monitor_pkg::*;

  localparam int W = 4;
`ifdef COUNT_MONITOR_STEP_CHECK_EN
  localparam bit STEP_ON = 1'b1;
`else
  localparam bit STEP_ON = 1'b0;
`endif

  logic         clock;
  logic         clear;
  logic [W-1:0] count;
  logic [W-1:0] target;
  logic         arm;
  logic         wrap_pulse;
  logic [W-1:0] wrap_cnt;
  logic         wrap_ovf;
  logic         match_pulse;
  logic         busy;
  logic         step_err;

  count_monitor #(.WIDTH(W)) dut (
    .clock       (clock),
    .clear       (clear),
    .count       (count),
    .target      (target),
    .arm         (arm),
    .wrap_pulse  (wrap_pulse),
    .wrap_cnt    (wrap_cnt),
    .wrap_ovf    (wrap_ovf),
    .match_pulse (match_pulse),
    .busy        (busy),
    .step_err    (step_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: samples since clear, wrap total, one outstanding search
  int nedge, prev_s, wraps, tgt_m, last_hit, cnt;
  bit active, step_exp, exp_w, exp_m;

  task automatic model_reset();
    nedge = 0; prev_s = 0; wraps = 0; tgt_m = 0; last_hit = -10;
    active = 0; step_exp = 0; exp_w = 0; exp_m = 0;
  endtask

  task automatic model_edge(input int c, input bit a, input int t);
    int k;
    k = nedge;
    exp_w = (k >= 1) && (prev_s == 15) && (c == 0);
    if (exp_w) wraps++;
    if (active && c == tgt_m) begin
      active = 0;
      last_hit = k;
    end else if (!active && last_hit != k - 1 && a) begin
      active = 1;
      tgt_m = t;
    end
    exp_m = (last_hit == k);
    if (STEP_ON && k >= 1 && c != (prev_s + 1) % 16) step_exp = 1;
    prev_s = c;
    nedge++;
  endtask

  task automatic compare_all();
    check("wrap_pulse", wrap_pulse, exp_w);
    check("wrap_cnt", wrap_cnt, wraps % 16);
    check("wrap_ovf", wrap_ovf, wraps >= 16);
    check("match_pulse", match_pulse, exp_m);
    check("busy", busy, active);
    check("step_err", step_err, step_exp);
  endtask

  task automatic tick(input int c, input bit a, input int t);
    count = c[W-1:0];
    arm = a;
    target = t[W-1:0];
    @(posedge clock);
    model_edge(c, a, t);
    @(negedge clock);
    compare_all();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_wrap_pulse"}, wrap_pulse, 0);
    check({tag, "_wrap_cnt"}, wrap_cnt, 0);
    check({tag, "_wrap_ovf"}, wrap_ovf, 0);
    check({tag, "_match_pulse"}, match_pulse, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_step_err"}, step_err, 0);
  endtask

  // Asserted mid-cycle to exercise the asynchronous path, released after a negedge
  task automatic do_clear();
    clear = 1'b1;
    count = '0;
    arm = 1'b0;
    #1;
    check_zero("clr_async");
    @(posedge clock);
    @(negedge clock);
    check_zero("clr_hold");
    clear = 1'b0;
    model_reset();
    cnt = 0;
  endtask

  task automatic run_free(input int n);
    for (int i = 0; i < n; i++) begin
      tick(cnt, 1'b0, 0);
      cnt = (cnt + 1) % 16;
    end
  endtask

  int npulse;

  initial begin
    clear = 1'b0; count = '0; arm = 1'b0; target = '0;
    model_reset();
    cnt = 0;
    #2;
    do_clear();

    // Free-running 40 clocks: two wraps
    npulse = 0;
    for (int i = 0; i < 40; i++) begin
      tick(cnt, 1'b0, 0);
      cnt = (cnt + 1) % 16;
      if (wrap_pulse) npulse++;
    end
    check("wrap_pulses_40", npulse, 2);
    check("wrap_cnt_40", wrap_cnt, 2);

    // 16 full periods roll wrap_cnt to 0 and set the sticky overflow
    do_clear();
    run_free(16 * 16 + 1);
    check("ovf_cnt16", wrap_cnt, 0);
    check("ovf_set", wrap_ovf, 1);
    run_free(16);
    check("ovf_cnt17", wrap_cnt, 1);
    check("ovf_sticky", wrap_ovf, 1);

    // Arm target 9 at count 3
    do_clear();
    run_free(3);
    tick(3, 1'b1, 9);
    check("arm9_busy", busy, 1);
    cnt = 4;
    run_free(6);
    check("hit9_match", match_pulse, 1);
    check("hit9_busy", busy, 0);
    run_free(1);
    check("after9_match", match_pulse, 0);

    // Clear while ARMED on a 15: no match, no wrap from the forced zero
    do_clear();
    run_free(12);
    tick(12, 1'b1, 0);
    cnt = 13;
    run_free(3);
    check("armed_pre_clr", busy, 1);
    do_clear();
    run_free(2);
    check("noclr_wrap", wrap_pulse, 0);
    check("noclr_match", match_pulse, 0);

    // Illegal step sequence 4,5,7
    do_clear();
    tick(4, 1'b0, 0);
    tick(5, 1'b0, 0);
    tick(7, 1'b0, 0);
    check("step_seq", step_err, STEP_ON);
    tick(8, 1'b0, 0);
    tick(9, 1'b0, 0);
    check("step_sticky", step_err, STEP_ON);

    // Target 0 coincident with a wrap
    do_clear();
    run_free(10);
    tick(10, 1'b1, 0);
    cnt = 11;
    run_free(6);
    check("coinc_wrap", wrap_pulse, 1);
    check("coinc_match", match_pulse, 1);

    // Randomized: mostly counting, occasional jumps, random arms and clears
    do_clear();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_clear();
      end else begin
        if ($urandom_range(0, 15) == 0) cnt = $urandom_range(0, 15);
        else cnt = (cnt + 1) % 16;
        tick(cnt, $urandom_range(0, 5) == 0, $urandom_range(0, 15));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/count_monitor.md
COUNT_MONITOR -- requirements
Module: count_monitor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the monitored count width; the design SHALL be verified at WIDTH=4.
REQ-002 Port: clock  input  1  rising-edge system clock, shared with the upstream 4-bit counter.
REQ-003 Port: clear  input  1  asynchronous, active-high reset, the same net that clears the upstream counter.
REQ-004 Port: count  input  WIDTH  counter output q, sampled on every rising clock edge.
REQ-005 Port: target  input  WIDTH  match value, captured when arm is high.
REQ-006 Port: arm  input  1  one-cycle request that starts a match search.
REQ-007 Port: wrap_pulse  output  1  registered, one-cycle pulse for each all-ones to zero transition.
REQ-008 Port: wrap_cnt  output  WIDTH  number of wraps seen, modulo 2^WIDTH.
REQ-009 Port: wrap_ovf  output  1  sticky flag, set when wrap_cnt rolls over.
REQ-010 Port: match_pulse  output  1  registered, one-cycle pulse when an armed search hits target.
REQ-011 Port: busy  output  1  high while the match FSM is in ARMED.
REQ-012 Port: step_err  output  1  sticky flag for an illegal count step (see Configuration).

Function
REQ-013 prev register: the block SHALL register count every cycle into prev.
- prev_vld SHALL be 0 after clear.
- prev_vld SHALL go to 1 on the first edge after clear deasserts.
REQ-014 Wrap detection: the block SHALL detect a wrap when all of the following hold:
- prev_vld=1
- prev = all-ones
- count = 0
REQ-015 Wrap response: on the edge after a wrap is detected, wrap_pulse SHALL be 1 for exactly one cycle, and wrap_cnt SHALL increment by 1 on that same edge.
REQ-016 wrap_cnt rollover: when wrap_cnt increments from all-ones to 0, wrap_ovf SHALL set on that same edge and hold until clear.
REQ-017 Match FSM states SHALL be IDLE, ARMED and HIT; the reset state SHALL be IDLE.
REQ-018 IDLE transition: IDLE->ARMED when arm=1; target SHALL be latched into tgt_q on that edge.
REQ-019 ARMED transitions:
- ARMED->HIT when count==tgt_q.
- arm is ignored while ARMED.
- A match is checked from the first cycle after arming, so the value present in the arming cycle does not count.
REQ-020 HIT state: HIT SHALL last exactly one cycle with match_pulse=1, then go to IDLE; arm=1 while in HIT SHALL be ignored.
REQ-021 busy SHALL equal (state==ARMED); match_pulse SHALL equal (state==HIT); both SHALL be glitch-free register outputs.
REQ-022 Simultaneous events: a wrap and a match in the same cycle SHALL both be reported independently in the same cycle.
REQ-023 Count width: all count arithmetic SHALL be WIDTH bits, unsigned and modulo 2^WIDTH; no output SHALL be X after reset.

Reset
REQ-024 clear=1 SHALL asynchronously force the following, regardless of clock:
- wrap_pulse=0, wrap_cnt=0, wrap_ovf=0
- match_pulse=0, busy=0, step_err=0
- state=IDLE, prev_vld=0, tgt_q=0
REQ-025 Mid-operation clear SHALL abort ARMED with no match_pulse; a clear that zeroes the counter SHALL NOT be reported as a wrap, because prev_vld=0.
REQ-026 Reset release SHALL be synchronous to clock; the first functional edge is the first rising edge with clear=0.

Configuration
REQ-027 Macro COUNT_MONITOR_STEP_CHECK_EN SHALL enable step checking.
- Defined: step_err SHALL set (sticky until clear) when prev_vld=1 and count != prev+1 modulo 2^WIDTH.
- Defined: the check SHALL include a hold, where count==prev.
- Not defined: step_err SHALL be tied to 0 and no step logic SHALL be synthesised.

Structure
REQ-028 The FSM state encodings (IDLE=2'd0, ARMED=2'd1, HIT=2'd2) and the default WIDTH SHALL live in shared package count_monitor_pkg.
REQ-029 The wrap/step logic SHALL be a sub-module, count_edge_detect, with inputs clock, clear, count and outputs wrap, step_bad.
REQ-030 The match FSM and the wrap_cnt register SHALL stay in the top module.

Verification
REQ-031 Scenario: free-running counter, clear released at t0, 40 clocks -> wrap_pulse high exactly twice, each one cycle after count goes 15->0; wrap_cnt=2.
REQ-032 Scenario: 16 full counter periods -> wrap_cnt returns to 0 and wrap_ovf=1; in the 17th period wrap_cnt=1 and wrap_ovf stays 1.
REQ-033 Scenario: arm=1 with target=9 while count=3 -> busy=1 next cycle; match_pulse=1 in the cycle after count==9; busy=0 and state IDLE afterwards.
REQ-034 Scenario: arm with target=0 and clear pulsed while ARMED -> no match_pulse; all outputs 0; no wrap_pulse from the forced zero.
REQ-035 Scenario: with COUNT_MONITOR_STEP_CHECK_EN defined, count is forced to the sequence 4,5,7 -> step_err=1 and stays 1 until clear; without the macro, step_err stays 0.
REQ-036 Scenario: arm with target=0 aligned to a wrap -> wrap_pulse and match_pulse both asserted in the same cycle.
